// File: rtl/chirp_frame_sequencer_pkg.sv
// chirp_seq_pkg: shared types and constants for the chirp frame sequencer.
//   seq_state_t : frame phase encoding; every chirp phase is split into an
//                 ISSUE cycle (start strobe low) and a WAIT period (until done).
//   SYNC_COUNT  : number of sync-word chirps per frame.
//   DOWN_COUNT  : number of downchirps per frame.
//   SYNC_SHIFT  : left shift applied to each sync nibble to form its symbol.
package chirp_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PRE_ISSUE,
    ST_PRE_WAIT,
    ST_SYNC_ISSUE,
    ST_SYNC_WAIT,
    ST_DOWN_ISSUE,
    ST_DOWN_WAIT,
    ST_PAY_ISSUE,
    ST_PAY_WAIT,
    ST_FIN
  } seq_state_t;

  localparam int unsigned SYNC_COUNT = 2;
  localparam int unsigned DOWN_COUNT = 2;
  localparam int unsigned SYNC_SHIFT = 3;

  function automatic logic is_issue(input seq_state_t s);
    return (s == ST_PRE_ISSUE) || (s == ST_SYNC_ISSUE) ||
           (s == ST_DOWN_ISSUE) || (s == ST_PAY_ISSUE);
  endfunction

endpackage

// File: rtl/chirp_frame_sequencer_fifo.sv
// sym_fifo: single-clock payload symbol FIFO.
//   i_clk, i_rst     : clock, asynchronous active-high reset (flushes FIFO)
//   i_wr, i_wdata    : write request and data
//   i_rd             : pop request (ignored when empty)
//   i_clr_ovf        : clears the sticky overflow flag
//   o_rdata          : current head entry
//   o_empty, o_full  : occupancy flags
//   o_overflow       : sticky; set when a write was dropped
module sym_fifo
  import chirp_seq_pkg::*;
#(
  parameter int unsigned SYM_WIDTH  = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_wr,
  input  logic [SYM_WIDTH-1:0] i_wdata,
  input  logic                 i_rd,
  input  logic                 i_clr_ovf,
  output logic [SYM_WIDTH-1:0] o_rdata,
  output logic                 o_empty,
  output logic                 o_full,
  output logic                 o_overflow
);

  localparam int unsigned ADDR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W  = ADDR_W + 1;

  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [SYM_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic                 r_overflow;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_rd_ok;
  logic                 w_wr_ok;

  // Extra pointer MSB distinguishes full from empty when the address bits match.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                   (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
  assign w_rd_ok = i_rd && !w_empty;
  // A pop in the same cycle frees the slot, so a write at full still lands.
  assign w_wr_ok = i_wr && (!w_full || w_rd_ok);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      // A drop coinciding with a clear still leaves the flag set.
      if (i_wr && !w_wr_ok)  r_overflow <= 1'b1;
      else if (i_clr_ovf)    r_overflow <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr_ok) r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_wdata;
  end

  assign o_rdata    = r_mem[r_rd_ptr[ADDR_W-1:0]];
  assign o_empty    = w_empty;
  assign o_full     = w_full;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/chirp_frame_sequencer.sv
// chirp_frame_sequencer: buffers UART payload symbols and sequences one frame
// of preamble upchirps, sync chirps, downchirps and payload chirps, handshaking
// each chirp with the NCO (start strobe out, done pulse back).
//   i_clk, i_rst      : clock, asynchronous active-high reset
//   i_sym_valid_n     : active-low payload write strobe, data on i_sym
//   i_tx_start_n      : active-low frame start request (honoured in IDLE only)
//   i_pre_len         : preamble chirp count (latched at start, 0 = none)
//   i_sync_word       : two sync symbols, high nibble first, each << SYNC_SHIFT
//   i_chirp_done_n    : active-low chirp completion pulse
//   o_chirp_start_n   : active-low one-cycle chirp launch strobe
//   o_symbol          : symbol of the current chirp
//   o_downchirp       : current chirp is a downchirp
//   o_busy            : frame in progress
//   o_frame_done_n    : active-low one-cycle end-of-frame pulse
//   o_fifo_empty/full : payload buffer status
//   o_overflow        : sticky dropped-write flag, cleared on frame start
module chirp_frame_sequencer
  import chirp_seq_pkg::*;
#(
  parameter int unsigned SYM_WIDTH  = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned PRE_WIDTH  = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_sym_valid_n,
  input  logic [SYM_WIDTH-1:0] i_sym,
  input  logic                 i_tx_start_n,
  input  logic [PRE_WIDTH-1:0] i_pre_len,
  input  logic [7:0]           i_sync_word,
  input  logic                 i_chirp_done_n,
  output logic                 o_chirp_start_n,
  output logic [SYM_WIDTH-1:0] o_symbol,
  output logic                 o_downchirp,
  output logic                 o_busy,
  output logic                 o_frame_done_n,
  output logic                 o_fifo_empty,
  output logic                 o_fifo_full,
  output logic                 o_overflow
);

  localparam int unsigned CNT_W = (PRE_WIDTH > 2) ? PRE_WIDTH : 2;

  seq_state_t           r_state;
  seq_state_t           w_state_next;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_next;
  logic [PRE_WIDTH-1:0] r_pre_len;
  logic                 r_chirp_start_n;
  logic [SYM_WIDTH-1:0] r_symbol;
  logic                 r_downchirp;
  logic                 r_busy;
  logic                 r_frame_done_n;

  logic                 w_start;
  logic                 w_done;
  logic                 w_pop;
  logic                 w_issue_next;
  logic [SYM_WIDTH-1:0] w_sym_next;
  logic                 w_down_next;
  logic [SYM_WIDTH-1:0] w_fifo_rdata;
  logic                 w_fifo_empty;
  logic [SYNC_SHIFT+3:0] w_sync_hi;
  logic [SYNC_SHIFT+3:0] w_sync_lo;

  assign w_start   = !i_tx_start_n && (r_state == ST_IDLE);
  assign w_done    = !i_chirp_done_n;
  // The head was already captured into o_symbol on entry to ISSUE.
  assign w_pop     = (r_state == ST_PAY_ISSUE);
  assign w_sync_hi = {i_sync_word[7:4], {SYNC_SHIFT{1'b0}}};
  assign w_sync_lo = {i_sync_word[3:0], {SYNC_SHIFT{1'b0}}};

  sym_fifo #(
    .SYM_WIDTH  (SYM_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_wr       (!i_sym_valid_n),
    .i_wdata    (i_sym),
    .i_rd       (w_pop),
    .i_clr_ovf  (w_start),
    .o_rdata    (w_fifo_rdata),
    .o_empty    (w_fifo_empty),
    .o_full     (o_fifo_full),
    .o_overflow (o_overflow)
  );

  // Next state and per-phase chirp counter. Done is only acted on in WAIT states.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_cnt_next   = '0;
          w_state_next = (i_pre_len != '0) ? ST_PRE_ISSUE : ST_SYNC_ISSUE;
        end
      end
      ST_PRE_ISSUE:  w_state_next = ST_PRE_WAIT;
      ST_PRE_WAIT: begin
        if (w_done) begin
          if ((r_cnt + CNT_W'(1)) == CNT_W'(r_pre_len)) begin
            w_cnt_next   = '0;
            w_state_next = ST_SYNC_ISSUE;
          end else begin
            w_cnt_next   = r_cnt + CNT_W'(1);
            w_state_next = ST_PRE_ISSUE;
          end
        end
      end
      ST_SYNC_ISSUE: w_state_next = ST_SYNC_WAIT;
      ST_SYNC_WAIT: begin
        if (w_done) begin
          if (r_cnt == CNT_W'(SYNC_COUNT - 1)) begin
            w_cnt_next   = '0;
            w_state_next = ST_DOWN_ISSUE;
          end else begin
            w_cnt_next   = r_cnt + CNT_W'(1);
            w_state_next = ST_SYNC_ISSUE;
          end
        end
      end
      ST_DOWN_ISSUE: w_state_next = ST_DOWN_WAIT;
      ST_DOWN_WAIT: begin
        if (w_done) begin
          if (r_cnt == CNT_W'(DOWN_COUNT - 1)) begin
            w_cnt_next   = '0;
            w_state_next = w_fifo_empty ? ST_FIN : ST_PAY_ISSUE;
          end else begin
            w_cnt_next   = r_cnt + CNT_W'(1);
            w_state_next = ST_DOWN_ISSUE;
          end
        end
      end
      ST_PAY_ISSUE:  w_state_next = ST_PAY_WAIT;
      ST_PAY_WAIT: begin
        if (w_done) w_state_next = w_fifo_empty ? ST_FIN : ST_PAY_ISSUE;
      end
      ST_FIN:        w_state_next = ST_IDLE;
      default:       w_state_next = ST_IDLE;
    endcase
  end

  // Symbol for the chirp about to be issued; sync uses the counter LSB to
  // pick the high nibble first.
  always_comb begin
    w_issue_next = is_issue(w_state_next);
    w_sym_next   = '0;
    w_down_next  = 1'b0;
    case (w_state_next)
      ST_SYNC_ISSUE: w_sym_next  = w_cnt_next[0] ? SYM_WIDTH'(w_sync_lo)
                                                 : SYM_WIDTH'(w_sync_hi);
      ST_DOWN_ISSUE: w_down_next = 1'b1;
      ST_PAY_ISSUE:  w_sym_next  = w_fifo_rdata;
      default:       ;
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with
  // the state they describe.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state         <= ST_IDLE;
      r_cnt           <= '0;
      r_pre_len       <= '0;
      r_chirp_start_n <= 1'b1;
      r_symbol        <= '0;
      r_downchirp     <= 1'b0;
      r_busy          <= 1'b0;
      r_frame_done_n  <= 1'b1;
    end else begin
      r_state         <= w_state_next;
      r_cnt           <= w_cnt_next;
      if (w_start) r_pre_len <= i_pre_len;
      r_chirp_start_n <= !w_issue_next;
      if (w_issue_next) begin
        r_symbol    <= w_sym_next;
        r_downchirp <= w_down_next;
      end
      r_busy          <= (w_state_next != ST_IDLE) && (w_state_next != ST_FIN);
      r_frame_done_n  <= (w_state_next != ST_FIN);
    end
  end

  assign o_chirp_start_n = r_chirp_start_n;
  assign o_symbol        = r_symbol;
  assign o_downchirp     = r_downchirp;
  assign o_busy          = r_busy;
  assign o_frame_done_n  = r_frame_done_n;
  assign o_fifo_empty    = w_fifo_empty;

endmodule

// File: doc/chirp_frame_sequencer.md
# chirp_frame_sequencer

Frame-level controller for the chirp modulator chain. Buffers payload symbols from the UART receiver and sequences one LoRa-style frame: preamble upchirps, two sync symbols, two downchirps, then the payload. Each chirp is launched with an active-low start strobe to the slope accumulator, and the next chirp is not launched until the NCO reports completion. The block sits between `uart_rx` and `slope_accumulator`/`nco_chirp`, replacing the direct UART-valid-to-start connection.

## Interface

**Parameters**
- `SYM_WIDTH`, 8: symbol width (equals `MAX_SF_WIDTH`).
- `FIFO_DEPTH`, 16: payload buffer depth; must be a power of 2.
- `PRE_WIDTH`, 4: width of the preamble length input.

**Ports**
- `i_clk`, in, 1: system clock (10 MHz).
- `i_rst`, in, 1: reset, asynchronous, active-high.
- `i_sym_valid_n`, in, 1: active-low one-cycle write strobe for `i_sym` (driven by `uart_rx` `o_valid_n`).
- `i_sym`, in, SYM_WIDTH: payload symbol.
- `i_tx_start_n`, in, 1: active-low frame start request.
- `i_pre_len`, in, PRE_WIDTH: number of preamble upchirps; 0 means no preamble.
- `i_sync_word`, in, 8: sync word; the two sync symbols are `{nibble, 3'b000}` (high nibble first), zero-extended or truncated to SYM_WIDTH.
- `i_chirp_done_n`, in, 1: active-low one-cycle completion pulse from `nco_chirp`.
- `o_chirp_start_n`, out, 1: active-low one-cycle chirp launch strobe.
- `o_symbol`, out, SYM_WIDTH: symbol for the current chirp; held stable from the start strobe until the next start strobe.
- `o_downchirp`, out, 1: high while the current chirp is a downchirp (selects negated slope).
- `o_busy`, out, 1: high from start acceptance until the frame-done cycle.
- `o_frame_done_n`, out, 1: active-low one-cycle end-of-frame pulse.
- `o_fifo_empty`, out, 1: payload buffer empty.
- `o_fifo_full`, out, 1: payload buffer full.
- `o_overflow`, out, 1: sticky flag; a write was dropped.

## Operation

- **Reset values:** `o_chirp_start_n`=1, `o_frame_done_n`=1, `o_symbol`=0, `o_downchirp`=0, `o_busy`=0, `o_overflow`=0, `o_fifo_empty`=1, `o_fifo_full`=0. The FIFO is flushed and the FSM enters IDLE.
- **FSM phases:** IDLE, PRE, SYNC, DOWN, PAYLOAD, FIN. Each chirp phase alternates between an ISSUE cycle and a WAIT period.
  - ISSUE: drive `o_chirp_start_n` low for one cycle and register `o_symbol`/`o_downchirp`. PRE uses symbol 0, up. SYNC uses the sync symbols, up. DOWN uses symbol 0 with `o_downchirp`=1. PAYLOAD uses the FIFO head and pops it in the ISSUE cycle.
  - WAIT: hold until `i_chirp_done_n` is sampled low.
- **Start:** `i_tx_start_n` low in IDLE is accepted. On acceptance, `o_overflow` clears and `o_busy` sets. In any other state the request is ignored.
- **Phase counts:** PRE issues `i_pre_len` chirps; the value is latched at acceptance, and PRE is skipped when it is 0. SYNC issues exactly 2 chirps. DOWN issues exactly 2 chirps.
- **PAYLOAD:** after each done, issue again if the FIFO is non-empty; otherwise go to FIN. A FIFO that is empty at DOWN completion skips PAYLOAD. Symbols written during the frame are transmitted if they arrive before the final done.
- **FIN:** one cycle with `o_frame_done_n`=0 and `o_busy` cleared in the same cycle, then IDLE.
- **Spurious done:** `i_chirp_done_n` low in IDLE, FIN, or an ISSUE cycle is ignored.
- **FIFO writes:** writes are accepted in every state.
  - Write when full with no simultaneous pop: the write is dropped and `o_overflow` is set.
  - Write and pop in the same cycle: both happen; occupancy is unchanged and a write at full is accepted.
  - Write when empty: `o_fifo_empty` deasserts next cycle. The symbol may be popped the cycle after that.
- **Pointer width:** read/write pointers are log2(FIFO_DEPTH)+1 bits and wrap naturally. Full when the MSBs differ and the LSBs are equal.
- **Reset mid-frame:** frame aborted, no done pulse, outputs return to reset values immediately (asynchronously).

## Timing

- Start sampled low at edge k → `o_chirp_start_n`=0 during cycle k+1.
- Done sampled low at edge m → next start strobe in cycle m+1. The chirp-to-chirp gap is one cycle plus the downstream latency.
- Last done sampled at edge m → `o_frame_done_n`=0 in cycle m+1.
- `o_symbol`/`o_downchirp` change only at the edge that asserts `o_chirp_start_n`.
- All outputs are registered; there are no combinational input-to-output paths.
- Total chirps per frame = `i_pre_len` + 4 + payload count.

## Structure

- **Package `chirp_seq_pkg`:** phase enum, `SYNC_COUNT`=2, `DOWN_COUNT`=2, `SYNC_SHIFT`=3.
- **Sub-module `sym_fifo`:** synchronous single-clock FIFO (parameters `SYM_WIDTH`, `FIFO_DEPTH`; outputs full/empty/overflow), with the same async active-high `i_rst`.
- **Top level:** FSM plus chirp counter (width max(PRE_WIDTH, 2)).

## Test plan

- **Basic frame:** `i_pre_len`=8, `i_sync_word`=0x34, payload 0x05, 0xA2. Reply with done 20 cycles after each start. Required: 14 start strobes with symbols 0×8, 0x18, 0x20, 0,0 (downchirp=1), 0x05, 0xA2, then one frame-done pulse one cycle after the last done.
- **Empty payload, no preamble:** `i_pre_len`=0, FIFO empty. Required: exactly 4 chirps, then done.
- **Overflow:** write 17 symbols in IDLE with depth 16. Required: `o_fifo_full`=1, `o_overflow`=1, and the 17th symbol is absent from the frame. The next accepted start clears `o_overflow`.
- **Simultaneous events:** write on the same cycle as a PAYLOAD pop with the FIFO full → no overflow. A second start and a spurious done while busy → no effect on the sequence.
- **Late write:** write a payload symbol during DOWN2 WAIT. Required: it is sent as a payload chirp.
- **Reset mid-PAYLOAD:** assert `i_rst` during PAYLOAD. Required: all outputs at reset values within the same cycle, FIFO empty, and no done pulse. A new frame then runs cleanly.
